// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//   Multi-cycle control unit for the 9-bit-instruction datapath. It decodes
//   opcode/fcode into the datapath CTRL_* strobes, produces the START init
//   pulse after a run request, stalls the PC while a load waits on memory and
//   stops issuing on a HALT instruction or when the datapath reports DONE.
//
// Parameters
//   INIT_CYCLES  cycles START stays high after a run request (>= 1)
//   LOAD_WAIT    extra WAIT cycles a load spends before writeback (0..7)
//
// Optional feature
//   CTRL_PERF_CNT_EN  when defined, adds instr_cnt (retired instructions) and
//                     stall_cnt (WAIT cycles), both 16-bit saturating.
//
// Ports
//   CLK, reset_n        clock, synchronous active-low reset
//   run_req             level request to start a program (IDLE/HALT only)
//   opcode, fcode       instr[8:5] and instr[0] from the datapath
//   dp_done             DONE from the datapath fetch unit
//   START               datapath init pulse
//   pc_en               one-cycle PC advance per retired instruction
//   CTRL_*              datapath control strobes
//   busy, halted        status: INIT/EXEC/WAIT and HALT respectively
//   illegal             sticky undefined-opcode flag, cleared by a new run
//   instr_cnt/stall_cnt performance counters (CTRL_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
   parameter int INIT_CYCLES = 2,
   parameter int LOAD_WAIT   = 1
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        run_req,
   input  logic [3:0]  opcode,
   input  logic        fcode,
   input  logic        dp_done,
   output logic        START,
   output logic        pc_en,
   output logic        CTRL_branch_rel_nz,
   output logic        CTRL_branch_rel_z,
   output logic        CTRL_branch_abs,
   output logic        CTRL_reg_write_en,
   output logic        CTRL_mem_to_reg,
   output logic        CTRL_alu_src,
   output logic        CTRL_alu_sc_in,
   output logic        CTRL_read_mem,
   output logic        CTRL_write_mem,
   output logic [2:0]  CTRL_alu_op,
   output logic        busy,
   output logic        halted,
   output logic        illegal
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [15:0] instr_cnt,
   output logic [15:0] stall_cnt
`endif
);

   localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [2:0]        WAIT_LAST = 3'(LOAD_WAIT - 1);

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_LOGIC = 4'h1;
   localparam logic [3:0] OP_SHIFT = 4'h2;
   localparam logic [3:0] OP_ADDI  = 4'h3;
   localparam logic [3:0] OP_LOAD  = 4'h4;
   localparam logic [3:0] OP_STORE = 4'h5;
   localparam logic [3:0] OP_BNZ   = 4'h6;
   localparam logic [3:0] OP_BZ    = 4'h7;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_CMP   = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_EXEC = 3'd2,
      S_WAIT = 3'd3,
      S_HALT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
   logic [2:0]        wait_cnt_q, wait_cnt_d;
   logic              illegal_q, illegal_d;
   logic              enter_init;

   always_comb begin
      state_d            = state_q;
      init_cnt_d         = init_cnt_q;
      wait_cnt_d         = wait_cnt_q;
      illegal_d          = illegal_q;
      enter_init         = 1'b0;
      START              = 1'b0;
      pc_en              = 1'b0;
      CTRL_branch_rel_nz = 1'b0;
      CTRL_branch_rel_z  = 1'b0;
      CTRL_branch_abs    = 1'b0;
      CTRL_reg_write_en  = 1'b0;
      CTRL_mem_to_reg    = 1'b0;
      CTRL_alu_src       = 1'b0;
      CTRL_alu_sc_in     = 1'b0;   // shifts always shift in zero
      CTRL_read_mem      = 1'b0;
      CTRL_write_mem     = 1'b0;
      CTRL_alu_op        = 3'd0;
      busy               = 1'b0;
      halted             = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run_req) enter_init = 1'b1;
         end

         S_INIT: begin
            START = 1'b1;
            busy  = 1'b1;
            if (init_cnt_q == INIT_LAST) state_d = S_EXEC;
            else                         init_cnt_d = init_cnt_q + 1'b1;
         end

         S_EXEC: begin
            busy = 1'b1;
            // A stop request suppresses every strobe, including pc_en.
            if (opcode == OP_HALT || dp_done) begin
               state_d = S_HALT;
            end else begin
               pc_en = 1'b1;
               case (opcode)
                  OP_ADD: begin
                     CTRL_alu_op       = fcode ? 3'd1 : 3'd0;
                     CTRL_reg_write_en = 1'b1;
                  end
                  OP_LOGIC: begin
                     CTRL_alu_op       = fcode ? 3'd3 : 3'd2;
                     CTRL_reg_write_en = 1'b1;
                  end
                  OP_SHIFT: begin
                     CTRL_alu_op       = fcode ? 3'd5 : 3'd4;
                     CTRL_reg_write_en = 1'b1;
                  end
                  OP_ADDI: begin
                     CTRL_alu_src      = 1'b1;
                     CTRL_reg_write_en = 1'b1;
                  end
                  OP_LOAD: begin
                     CTRL_read_mem   = 1'b1;
                     CTRL_mem_to_reg = 1'b1;
                     // With a memory wait the writeback and PC advance move
                     // to the last WAIT cycle.
                     if (LOAD_WAIT == 0) begin
                        CTRL_reg_write_en = 1'b1;
                     end else begin
                        pc_en      = 1'b0;
                        state_d    = S_WAIT;
                        wait_cnt_d = 3'd0;
                     end
                  end
                  OP_STORE: CTRL_write_mem     = 1'b1;
                  OP_BNZ:   CTRL_branch_rel_nz = 1'b1;
                  OP_BZ:    CTRL_branch_rel_z  = 1'b1;
                  OP_JMP:   CTRL_branch_abs    = 1'b1;
                  OP_CMP:   CTRL_alu_op        = 3'd1;
                  default:  illegal_d          = 1'b1;   // A-E retire as NOP
               endcase
            end
         end

         S_WAIT: begin
            busy            = 1'b1;
            CTRL_read_mem   = 1'b1;
            CTRL_mem_to_reg = 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
               CTRL_reg_write_en = 1'b1;
               pc_en             = 1'b1;
               state_d           = S_EXEC;
            end else begin
               wait_cnt_d = wait_cnt_q + 3'd1;
            end
         end

         S_HALT: begin
            halted = 1'b1;
            if (run_req) enter_init = 1'b1;
         end

         default: state_d = S_IDLE;
      endcase

      if (enter_init) begin
         state_d    = S_INIT;
         init_cnt_d = '0;
         illegal_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         init_cnt_q <= '0;
         wait_cnt_q <= 3'd0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
      end
   end

   assign illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
   logic [15:0] instr_cnt_q, instr_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      instr_cnt_d = instr_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (enter_init) begin
         instr_cnt_d = 16'd0;
         stall_cnt_d = 16'd0;
      end else begin
         if (pc_en)              instr_cnt_d = sat_inc16(instr_cnt_q);
         if (state_q == S_WAIT)  stall_cnt_d = sat_inc16(stall_cnt_q);
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         instr_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign instr_cnt = instr_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sequencer
//   Self-checking bench for ctrl_sequencer (INIT_CYCLES=2, LOAD_WAIT=1).
//   A directed vector table and short hand-written sequences are followed by
//   randomized stimulus checked against a cycle-count based reference model.
// ---------------------------------------------------------------------------
module tb_ctrl_sequencer;

   localparam int INIT_CYCLES = 2;
   localparam int LOAD_WAIT   = 1;

   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic       run_req = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic       fcode = 1'b0;
   logic       dp_done = 1'b0;

   logic       START, pc_en, br_nz, br_z, br_abs, rw, m2r, alu_src, sc_in;
   logic       rd, wr, busy, halted, illegal;
   logic [2:0] alu_op;
`ifdef CTRL_PERF_CNT_EN
   logic [15:0] instr_cnt, stall_cnt;
`endif

   always #5 CLK = ~CLK;

   ctrl_sequencer #(.INIT_CYCLES(INIT_CYCLES), .LOAD_WAIT(LOAD_WAIT)) dut (
      .CLK                (CLK),
      .reset_n            (reset_n),
      .run_req            (run_req),
      .opcode             (opcode),
      .fcode              (fcode),
      .dp_done            (dp_done),
      .START              (START),
      .pc_en              (pc_en),
      .CTRL_branch_rel_nz (br_nz),
      .CTRL_branch_rel_z  (br_z),
      .CTRL_branch_abs    (br_abs),
      .CTRL_reg_write_en  (rw),
      .CTRL_mem_to_reg    (m2r),
      .CTRL_alu_src       (alu_src),
      .CTRL_alu_sc_in     (sc_in),
      .CTRL_read_mem      (rd),
      .CTRL_write_mem     (wr),
      .CTRL_alu_op        (alu_op),
      .busy               (busy),
      .halted             (halted),
      .illegal            (illegal)
`ifdef CTRL_PERF_CNT_EN
      ,
      .instr_cnt          (instr_cnt),
      .stall_cnt          (stall_cnt)
`endif
   );

   // Bit layout of expected constants:
   //   start|pc_en|nz z abs|rw m2r src|sc|rd wr|alu_op|busy|halted|illegal
   typedef struct packed {
      logic       start;
      logic       pc_en;
      logic       br_nz;
      logic       br_z;
      logic       br_abs;
      logic       rw;
      logic       m2r;
      logic       alu_src;
      logic       sc_in;
      logic       rd;
      logic       wr;
      logic [2:0] alu_op;
      logic       busy;
      logic       halted;
      logic       ill;
   } outs_t;

   typedef struct {
      logic       rn;
      logic       rr;
      logic [3:0] op;
      logic       f;
      logic       dn;
      outs_t      exp;
   } vec_t;

   outs_t act;
   assign act = {START, pc_en, br_nz, br_z, br_abs, rw, m2r, alu_src, sc_in,
                 rd, wr, alu_op, busy, halted, illegal};

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[$];

   // Reference model: remaining cycles of the START pulse and of a load's
   // memory wait, plus program running/stopped status.
   int m_init_left = 0;
   int m_load_left = 0;
   bit m_running = 0;
   bit m_stopped = 0;
   bit m_ill = 0;
   int m_instr = 0;
   int m_stall = 0;

   // Controls of an instruction that retires in a single EXEC cycle.
   function automatic outs_t ref_ctl(input logic [3:0] op, input logic f);
      outs_t e = '0;
      e.pc_en = 1'b1;
      case (op)
         4'h0: begin e.alu_op = f ? 3'd1 : 3'd0; e.rw = 1'b1; end
         4'h1: begin e.alu_op = f ? 3'd3 : 3'd2; e.rw = 1'b1; end
         4'h2: begin e.alu_op = f ? 3'd5 : 3'd4; e.rw = 1'b1; end
         4'h3: begin e.alu_src = 1'b1; e.rw = 1'b1; end
         4'h4: begin e.rd = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; end
         4'h5: e.wr = 1'b1;
         4'h6: e.br_nz = 1'b1;
         4'h7: e.br_z = 1'b1;
         4'h8: e.br_abs = 1'b1;
         4'h9: e.alu_op = 3'd1;
         default: ;
      endcase
      return e;
   endfunction

   function automatic outs_t model_exp(input logic [3:0] op, input logic f, input logic dn);
      outs_t e = '0;
      if (m_init_left > 0) begin
         e.start = 1'b1;
         e.busy  = 1'b1;
      end else if (m_load_left > 0) begin
         e.busy = 1'b1;
         e.rd   = 1'b1;
         e.m2r  = 1'b1;
         if (m_load_left == 1) begin
            e.rw    = 1'b1;
            e.pc_en = 1'b1;
         end
      end else if (m_running) begin
         if (!(op == 4'hF || dn)) begin
            e = ref_ctl(op, f);
            if (op == 4'h4 && LOAD_WAIT > 0) begin
               e.rw    = 1'b0;
               e.pc_en = 1'b0;
            end
         end
         e.busy = 1'b1;
      end
      e.halted = m_stopped;
      e.ill    = m_ill;
      return e;
   endfunction

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_tick(input logic rn, input logic rr, input logic [3:0] op,
                             input logic dn, input logic pce);
      if (!rn) begin
         m_init_left = 0; m_load_left = 0; m_running = 0; m_stopped = 0;
         m_ill = 0; m_instr = 0; m_stall = 0;
      end else if (m_init_left > 0) begin
         m_init_left--;
      end else if (m_load_left > 0) begin
         m_stall = sat16(m_stall);
         if (pce) m_instr = sat16(m_instr);
         m_load_left--;
      end else if (m_running) begin
         if (pce) m_instr = sat16(m_instr);
         if (op == 4'hF || dn) begin
            m_running = 0;
            m_stopped = 1;
         end else if (op == 4'h4 && LOAD_WAIT > 0) begin
            m_load_left = LOAD_WAIT;
         end else if (op >= 4'hA && op <= 4'hE) begin
            m_ill = 1;
         end
      end else if (rr) begin
         m_init_left = INIT_CYCLES;
         m_running = 1; m_stopped = 0; m_ill = 0;
         m_instr = 0; m_stall = 0;
      end
   endtask

   // One clock: drive at the falling edge, check 2 time units later, then
   // advance the model to match the following rising edge.
   task automatic chk_step(input logic rn, input logic rr, input logic [3:0] op,
                           input logic f, input logic dn, input outs_t exp_in,
                           input bit use_model, input string name);
      outs_t e;
      outs_t me;
      @(negedge CLK);
      reset_n = rn; run_req = rr; opcode = op; fcode = f; dp_done = dn;
      #2;
      me = model_exp(op, f, dn);
      e  = use_model ? me : exp_in;
      n_cmp++;
      if (act !== e) begin
         n_bad++;
         $display("FAIL %s: outputs got %b want %b", name, act, e);
      end
`ifdef CTRL_PERF_CNT_EN
      if (use_model) begin
         n_cmp++;
         if (instr_cnt !== 16'(m_instr) || stall_cnt !== 16'(m_stall)) begin
            n_bad++;
            $display("FAIL %s perf: instr/stall got %0d/%0d want %0d/%0d",
                     name, instr_cnt, stall_cnt, m_instr, m_stall);
         end
      end
`endif
      model_tick(rn, rr, op, dn, me.pc_en);
   endtask

   task automatic add(input logic rn, input logic rr, input logic [3:0] op,
                      input logic f, input logic dn, input logic [16:0] exp);
      vec_t v;
      v.rn = rn; v.rr = rr; v.op = op; v.f = f; v.dn = dn; v.exp = outs_t'(exp);
      tbl.push_back(v);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //   rn    rr    op    f     dn    start|pc|brs|rw m2r src|sc|rd wr|op|busy|halt|ill
      add(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_0_0_0);
      add(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_0_0_0);
      add(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_0_0_0);
      add(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_0_0_0);
      add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 17'b1_0_000_000_0_00_000_1_0_0);
      add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 17'b1_0_000_000_0_00_000_1_0_0);
      add(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 17'b0_1_000_100_0_00_001_1_0_0);
      add(1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 17'b0_0_000_010_0_10_000_1_0_0);
      add(1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 17'b0_1_000_110_0_10_000_1_0_0);
      add(1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 17'b0_1_100_000_0_00_000_1_0_0);
      add(1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 17'b0_1_000_000_0_00_000_1_0_0);
      add(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 17'b0_1_000_000_0_01_000_1_0_1);
      add(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 17'b0_1_000_101_0_00_000_1_0_1);
      add(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 17'b0_1_000_100_0_00_011_1_0_1);
      add(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 17'b0_1_000_100_0_00_101_1_0_1);
      add(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 17'b0_1_010_000_0_00_000_1_0_1);
      add(1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 17'b0_1_001_000_0_00_000_1_0_1);
      add(1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 17'b0_1_000_000_0_00_001_1_0_1);
      add(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_1_0_1);
      add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_0_1_1);
      add(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_0_1_1);
      add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 17'b1_0_000_000_0_00_000_1_0_0);
      add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 17'b1_0_000_000_0_00_000_1_0_0);
      add(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 17'b0_0_000_000_0_00_000_1_0_0);
      add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 17'b0_0_000_000_0_00_000_0_1_0);

      for (int i = 0; i < tbl.size(); i++) begin
`ifdef CTRL_PERF_CNT_EN
         if (i == 19 || i == 22) begin
            @(negedge CLK);
            #2;
            n_cmp++;
            if (instr_cnt !== ((i == 19) ? 16'd11 : 16'd0) ||
                stall_cnt !== ((i == 19) ? 16'd1 : 16'd0)) begin
               n_bad++;
               $display("FAIL tbl_perf[%0d]: instr/stall got %0d/%0d", i, instr_cnt, stall_cnt);
            end
         end
`endif
         chk_step(tbl[i].rn, tbl[i].rr, tbl[i].op, tbl[i].f, tbl[i].dn, tbl[i].exp, 1'b0,
                  $sformatf("tbl[%0d]", i));
      end

      // HALT opcode and dp_done together give a single HALT entry.
      chk_step(1, 1, 4'h0, 0, 0, outs_t'(17'b0_0_000_000_0_00_000_0_1_0), 0, "dual_halt_req");
      chk_step(1, 0, 4'h0, 0, 0, outs_t'(17'b1_0_000_000_0_00_000_1_0_0), 0, "dual_init1");
      chk_step(1, 0, 4'h0, 0, 0, outs_t'(17'b1_0_000_000_0_00_000_1_0_0), 0, "dual_init2");
      chk_step(1, 0, 4'hF, 0, 1, outs_t'(17'b0_0_000_000_0_00_000_1_0_0), 0, "dual_stop");
      chk_step(1, 0, 4'h0, 0, 0, outs_t'(17'b0_0_000_000_0_00_000_0_1_0), 0, "dual_halt1");
      chk_step(1, 0, 4'h6, 0, 0, outs_t'(17'b0_0_000_000_0_00_000_0_1_0), 0, "dual_halt2");

      // Reset during a load wait wins and returns to IDLE.
      chk_step(1, 1, 4'h0, 0, 0, outs_t'(17'b0_0_000_000_0_00_000_0_1_0), 0, "rst_ld_req");
      chk_step(1, 0, 4'h0, 0, 0, outs_t'(17'b1_0_000_000_0_00_000_1_0_0), 0, "rst_ld_init1");
      chk_step(1, 0, 4'h0, 0, 0, outs_t'(17'b1_0_000_000_0_00_000_1_0_0), 0, "rst_ld_init2");
      chk_step(1, 0, 4'h4, 0, 0, outs_t'(17'b0_0_000_010_0_10_000_1_0_0), 0, "rst_ld_exec");
      chk_step(0, 1, 4'h4, 0, 0, outs_t'(17'b0_1_000_110_0_10_000_1_0_0), 0, "rst_ld_wait");
      chk_step(1, 0, 4'h4, 0, 0, outs_t'(17'b0_0_000_000_0_00_000_0_0_0), 0, "rst_ld_idle1");
      chk_step(1, 0, 4'h6, 0, 0, outs_t'(17'b0_0_000_000_0_00_000_0_0_0), 0, "rst_ld_idle2");

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         logic       rn, rr, f, dn;
         logic [3:0] op;
         rn = ($urandom_range(63) != 0);
         rr = ($urandom_range(3) == 0);
         op = 4'($urandom_range(15));
         if (op == 4'hF && $urandom_range(3) != 0) op = 4'($urandom_range(14));
         f  = 1'($urandom_range(1));
         dn = ($urandom_range(40) == 0);
         chk_step(rn, rr, op, f, dn, '0, 1'b1, $sformatf("rand[%0d]", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
